// File: rtl/lsu_mem_seq.sv
// Load/store sequencer: one request at a time, 64-bit accesses split into two 32-bit beats.
// Optional alignment check enabled by defining LSU_ALIGN_CHECK_EN.
module lsu_mem_seq #(
   parameter int unsigned MEM_BYTES = 512
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic        req_dbl,
   input  logic        req_unsigned,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic [63:0] mem_add,
   output logic [63:0] write_data,
   output logic        mem_write,
   output logic        mem_read,
   input  logic [63:0] read_data
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACC0 = 2'd1;
   localparam logic [1:0] S_ACC1 = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   logic [1:0]  r_state;
   logic [1:0]  w_next;
   logic        r_we;
   logic        r_dbl;
   logic        r_uns;
   logic        r_err;
   logic [63:0] r_addr;
   logic [63:0] r_wdata;
   logic [31:0] r_lo;
   logic [31:0] r_hi;
   logic        w_accept;
   logic        w_misal;
   logic        w_bad;
   logic [64:0] w_end;
   logic        w_unused_rd;

   assign w_unused_rd = ^read_data[63:32];
   assign w_accept    = req_valid && (r_state == S_IDLE);

   // 65-bit end address so an address near 2^64 cannot wrap into range
   assign w_end = {1'b0, req_addr} + (req_dbl ? 65'd8 : 65'd4);

`ifdef LSU_ALIGN_CHECK_EN
   assign w_misal = (req_addr[1:0] != 2'b00);
`else
   assign w_misal = 1'b0;
`endif

   assign w_bad = (w_end > 65'(MEM_BYTES)) || w_misal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next state and state-decoded outputs; memory strobes vanish with the state on reset
   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = 64'd0;
      mem_add    = 64'd0;
      write_data = 64'd0;
      mem_write  = 1'b0;
      mem_read   = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (w_accept) w_next = w_bad ? S_RESP : S_ACC0;
         end
         S_ACC0: begin
            mem_add    = r_addr;
            write_data = {32'd0, r_wdata[31:0]};
            mem_write  = r_we;
            mem_read   = !r_we;
            w_next     = r_dbl ? S_ACC1 : S_RESP;
         end
         S_ACC1: begin
            mem_add    = r_addr + 64'd4;
            write_data = {32'd0, r_wdata[63:32]};
            mem_write  = r_we;
            mem_read   = !r_we;
            w_next     = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            resp_err   = r_err;
            if (!r_err && !r_we) begin
               if (r_dbl)      resp_rdata = {r_hi, r_lo};
               else if (r_uns) resp_rdata = {32'd0, r_lo};
               else            resp_rdata = {{32{r_lo[31]}}, r_lo};
            end
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we    <= 1'b0;
         r_dbl   <= 1'b0;
         r_uns   <= 1'b0;
         r_err   <= 1'b0;
         r_addr  <= 64'd0;
         r_wdata <= 64'd0;
         r_lo    <= 32'd0;
         r_hi    <= 32'd0;
      end else begin
         if (w_accept) begin
            r_we    <= req_we;
            r_dbl   <= req_dbl;
            r_uns   <= req_unsigned;
            r_err   <= w_bad;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
         end
         if ((r_state == S_ACC0) && !r_we) r_lo <= read_data[31:0];
         if ((r_state == S_ACC1) && !r_we) r_hi <= read_data[31:0];
      end
   end

endmodule

// File: tb/tb_lsu_mem_seq.sv
// Scoreboard bench for lsu_mem_seq: byte-array reference model, directed scenarios plus random traffic.
module tb_lsu_mem_seq;

   localparam int unsigned MEM_BYTES = 512;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_dbl, req_unsigned;
   logic [63:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [63:0] resp_rdata, mem_add, write_data, read_data;
   logic        mem_write, mem_read;

   logic [7:0]  dmem [MEM_BYTES];
   logic [7:0]  rmem [MEM_BYTES];
   exp_t        q[$];
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   int          prev_acc = 0;
   int          prev_lat = 0;
   bit          prev_keep = 1'b0;
   logic [8:0]  a0, a1, a2, a3;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lsu_mem_seq #(.MEM_BYTES(MEM_BYTES)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_dbl(req_dbl),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_add(mem_add), .write_data(write_data), .mem_write(mem_write), .mem_read(mem_read),
      .read_data(read_data)
   );

   // Little-endian byte memory behind the DUT; upper read half carries junk
   assign a0 = mem_add[8:0];
   assign a1 = 9'(a0 + 9'd1);
   assign a2 = 9'(a0 + 9'd2);
   assign a3 = 9'(a0 + 9'd3);
   assign read_data = {32'hA5A5_5A5A, dmem[a3], dmem[a2], dmem[a1], dmem[a0]};

   always @(posedge clk) begin
      if (mem_write) begin
         dmem[a0] <= write_data[7:0];
         dmem[a1] <= write_data[15:8];
         dmem[a2] <= write_data[23:16];
         dmem[a3] <= write_data[31:24];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: accesses are sequential, so memory effects are applied at issue time
   function automatic exp_t model(input logic we, input logic dbl, input logic uns,
                                  input logic [63:0] addr, input logic [63:0] wdata);
      exp_t e;
      int n;
      logic [63:0] v;
      n = dbl ? 8 : 4;
      e.err = (addr > 64'(MEM_BYTES - n));
`ifdef LSU_ALIGN_CHECK_EN
      if (addr[1:0] != 2'b00) e.err = 1'b1;
`endif
      e.lat   = e.err ? 1 : (dbl ? 3 : 2);
      e.rdata = 64'd0;
      e.acc   = 0;
      if (!e.err) begin
         if (we) begin
            for (int i = 0; i < n; i++) rmem[int'(addr) + i] = wdata[8*i +: 8];
         end else begin
            v = 64'd0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = rmem[int'(addr) + i];
            if (!dbl) v = uns ? {32'd0, v[31:0]} : {{32{v[31]}}, v[31:0]};
            e.rdata = v;
         end
      end
      return e;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge
   task automatic issue(input logic we, input logic dbl, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata, input bit keep);
      exp_t e;
      int w;
      req_valid = 1'b1; req_we = we; req_dbl = dbl; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      w = 0;
      while (!req_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("accept_timeout", 64'(req_ready), 64'd1);
      if (prev_keep) check("b2b_spacing", 64'(cyc - prev_acc), 64'(prev_lat + 1));
      e = model(we, dbl, uns, addr, wdata);
      e.acc = cyc;
      q.push_back(e);
      prev_acc = cyc; prev_lat = e.lat; prev_keep = keep;
      @(negedge clk);
      check("ready_low_busy", 64'(req_ready), 64'd0);
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      req_valid = 1'b0;
      prev_keep = 1'b0;
      while (q.size() != 0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("drain_pending", 64'(q.size()), 64'd0);
      q.delete();
   endtask

   // Monitor: compares each response pulse against the oldest expectation
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_read || mem_write) begin
            check("rd_wr_exclusive", 64'(mem_read && mem_write), 64'd0);
            check("ctrl_idle_resp", 64'(req_ready || resp_valid), 64'd0);
         end
         if (mem_write) check("wdata_upper", write_data[63:32], 64'd0);
         if (resp_valid) begin
            if (q.size() == 0) begin
               check("unexpected_resp", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("resp_rdata", resp_rdata, e.rdata);
               check("resp_err", 64'(resp_err), 64'(e.err));
               check("resp_latency", 64'(cyc - e.acc), 64'(e.lat));
            end
         end
      end
   end

   initial begin
      logic [63:0] addr;
      int r;
      for (int i = 0; i < int'(MEM_BYTES); i++) begin
         dmem[i] = 8'($urandom);
         rmem[i] = dmem[i];
      end
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_dbl = 1'b0; req_unsigned = 1'b0;
      req_addr = 64'd0; req_wdata = 64'd0;
      repeat (3) @(negedge clk);
      check("rst_ready", 64'(req_ready), 64'd1);
      check("rst_resp", {resp_rdata[61:0], resp_valid, resp_err}, 64'd0);
      check("rst_mem_ctrl", {mem_add[61:0], mem_write, mem_read}, 64'd0);
      check("rst_wdata", write_data, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // T1
      issue(1, 0, 0, 64'h100, 64'h1234_5678_DEAD_BEEF, 0);
      issue(0, 0, 0, 64'h100, 64'd0, 0);
      issue(0, 0, 1, 64'h100, 64'd0, 0);
      drain();
      // T2
      issue(1, 1, 0, 64'h108, 64'h1122_3344_5566_7788, 0);
      issue(0, 1, 1, 64'h108, 64'd0, 0);
      issue(0, 0, 1, 64'h10C, 64'd0, 0);
      drain();
      // T3
      issue(0, 1, 0, 64'h1FC, 64'd0, 0);
      issue(0, 0, 0, 64'h1FC, 64'd0, 0);
      issue(1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0BAD_0BAD_0BAD_0BAD, 0);
      issue(1, 1, 0, 64'h1F8, 64'hCAFE_F00D_0123_4567, 0);
      drain();
      // T4
      issue(0, 0, 0, 64'h102, 64'd0, 0);
      drain();

      // T5: reset lands while the upper beat of a store is on the bus
      req_valid = 1'b1; req_we = 1'b1; req_dbl = 1'b1; req_unsigned = 1'b0;
      req_addr = 64'h110; req_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
      check("t5_ready", 64'(req_ready), 64'd1);
      @(negedge clk);
      req_valid = 1'b0;
      check("t5_acc0_write", {mem_add[62:0], mem_write}, {63'h110, 1'b1});
      @(negedge clk);
      check("t5_acc1_write", {mem_add[62:0], mem_write}, {63'h114, 1'b1});
      rst_n = 1'b0;
      #1;
      check("t5_write_drop", 64'(mem_write), 64'd0);
      check("t5_ready_rst", 64'(req_ready), 64'd1);
      check("t5_no_resp", 64'(resp_valid), 64'd0);
      for (int i = 0; i < 4; i++) rmem[16'h110 + i] = 8'(32'hCCCC_DDDD >> (8 * i));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(0, 1, 0, 64'h110, 64'd0, 0);
      drain();

      // T6: requester holds valid across a LW then a SW
      issue(0, 0, 0, 64'h108, 64'd0, 1);
      issue(1, 0, 0, 64'h120, 64'h0000_0000_8000_0001, 1);
      issue(0, 0, 0, 64'h120, 64'd0, 0);
      drain();

      for (int n = 0; n < 300; n++) begin
         r = int'($urandom_range(0, 9));
         if (r < 7)       addr = 64'($urandom_range(0, 127) * 4);
         else if (r == 7) addr = 64'($urandom_range(496, 520));
         else if (r == 8) addr = {$urandom, $urandom};
         else             addr = 64'($urandom_range(0, 511));
         issue(1'($urandom), 1'($urandom), 1'($urandom), addr, {$urandom, $urandom},
               bit'($urandom_range(0, 1)));
         if (!prev_keep) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();

      for (int i = 0; i < int'(MEM_BYTES); i++) check("mem_image", 64'(dmem[i]), 64'(rmem[i]));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $fatal(1, "timeout");
   end

endmodule
